// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the main-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STORE = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int BLK_OFF_W     = 4;
  localparam int WORDS_DEFAULT = 8;

endpackage

// File: rtl/mem_port_arbiter_fill_counter.sv
// Issue/return word counters for one block refill; cleared whenever no fill is active.
module fill_counter #(
  parameter int WORDS = 8,
  parameter int IDX_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             iss_en,
  input  logic             ret_en,
  output logic [IDX_W-1:0] iss,
  output logic [IDX_W-1:0] ret,
  output logic             iss_done,
  output logic             ret_last
);

  logic iss_last;

  assign iss_last = (iss == IDX_W'(WORDS - 1));
  assign ret_last = (ret == IDX_W'(WORDS - 1));

  // iss wraps to 0 after the last issue; iss_done is what stops further reads.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      iss      <= '0;
      ret      <= '0;
      iss_done <= 1'b0;
    end else begin
      if (iss_en && !iss_done) begin
        iss <= iss + 1'b1;
        if (iss_last) iss_done <= 1'b1;
      end
      if (ret_en) ret <= ret + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Main-memory port arbiter: store > D-miss > I-miss, pipelined 8-word refills.
// Build option MEM_ARB_ROUND_ROBIN_EN: alternate I/D on simultaneous misses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 4,
  parameter int WORDS   = WORDS_DEFAULT,
  parameter int ADDR_W  = 16,
  parameter int IDX_W   = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [15:0]       st_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_data_valid,
  output logic [15:0]       fill_data,
  output logic [IDX_W-1:0]  fill_idx,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              st_ack,
  output logic              busy
);

  // Byte offset within a block: word index plus the 16-bit byte lane bit.
  localparam int OFF_W = IDX_W + 1;
  localparam int BLK_W = ADDR_W - OFF_W;

  arb_state_e        state, state_nx;
  owner_e            owner, owner_nx;
  logic [BLK_W-1:0]  blk, blk_nx;
  logic [ADDR_W-1:0] st_addr_q;
  logic [15:0]       st_data_q;
  logic              pick_d;

  logic [IDX_W-1:0]  iss, ret;
  logic              iss_done, ret_last;
  logic              in_fill;

  logic unused_bits;
  assign unused_bits = ^{i_miss_addr[OFF_W-1:0], d_miss_addr[OFF_W-1:0], (MEM_LAT > 0)};

  assign in_fill = (state == ST_FILL);

  fill_counter #(.WORDS(WORDS), .IDX_W(IDX_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (!in_fill),
    .iss_en   (in_fill),
    .ret_en   (in_fill && mem_data_valid),
    .iss      (iss),
    .ret      (ret),
    .iss_done (iss_done),
    .ret_last (ret_last)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Remembers the side of the last fill grant; reset to I so the first tie goes to D.
  logic last_d;

  assign pick_d = d_miss && !(i_miss && last_d);

  always_ff @(posedge clk) begin
    if (!rst_n)
      last_d <= 1'b0;
    else if (state == ST_IDLE && !st_req && (d_miss || i_miss))
      last_d <= pick_d;
  end
`else
  assign pick_d = d_miss;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      owner     <= OWN_NONE;
      blk       <= '0;
      st_addr_q <= '0;
      st_data_q <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      blk   <= blk_nx;
      if (state == ST_IDLE && st_req) begin
        st_addr_q <= st_addr;
        st_data_q <= st_data;
      end
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    blk_nx   = blk;
    case (state)
      ST_IDLE: begin
        if (st_req) begin
          state_nx = ST_STORE;
        end else if (d_miss || i_miss) begin
          state_nx = ST_FILL;
          owner_nx = pick_d ? OWN_D : OWN_I;
          blk_nx   = pick_d ? d_miss_addr[ADDR_W-1:OFF_W] : i_miss_addr[ADDR_W-1:OFF_W];
        end
      end
      ST_STORE: state_nx = ST_IDLE;
      ST_FILL:  if (mem_data_valid && ret_last) state_nx = ST_DONE;
      ST_DONE: begin
        state_nx = ST_IDLE;
        owner_nx = OWN_NONE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // fill_data is gated so nothing leaks to the caches outside an active fill.
  always_comb begin
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_data   = '0;
    fill_idx    = '0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    st_ack      = 1'b0;
    busy        = (state != ST_IDLE);
    case (state)
      ST_STORE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = st_addr_q;
        mem_wdata = st_data_q;
        st_ack    = 1'b1;
      end
      ST_FILL: begin
        if (!iss_done) begin
          mem_en   = 1'b1;
          mem_addr = {blk, iss, 1'b0};
        end
        if (mem_data_valid) begin
          fill_data = mem_rdata;
          fill_idx  = ret;
          i_fill_we = (owner == OWN_I);
          d_fill_we = (owner == OWN_D);
        end
      end
      ST_DONE: begin
        i_fill_done = (owner == OWN_I);
        d_fill_done = (owner == OWN_D);
      end
      default: ;
    endcase
  end

endmodule
